// File: rtl/multidigit_scan_display.sv
// Time-multiplexed N-digit seven-segment driver: latches a hex value on load,
// scans one-hot digit selects at SCAN_DIV cycles per digit and drives the decoded segments.
module multidigit_scan_display #(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic [NDIGITS-1:0]     dp,
  input  logic                   load,
  input  logic                   blank_lz,
  input  logic                   enable,
  output logic [7:0]             led,
  output logic [NDIGITS-1:0]     sel,
  output logic                   frame_done
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

  // Segment table returns led[7:1] (g..a); the dp bit is appended separately.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h58;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [4*NDIGITS-1:0] val_q, val_d;
  logic [NDIGITS-1:0]   dp_q, dp_d;
  logic [PRE_W-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           led_q, led_d;
  logic [NDIGITS-1:0]   sel_q, sel_d;
  logic                 frame_done_q, frame_done_d;

  logic                 tick;
  logic [3:0]           nibble;
  logic [6:0]           seg_code;
  logic                 digit_blank;

  always_comb begin
    tick         = enable && (presc_q == LAST_PRE);
    presc_d      = presc_q;
    idx_d        = idx_q;
    frame_done_d = tick && (idx_q == LAST_IDX);
    if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    val_d = load ? value : val_q;
    dp_d  = load ? dp : dp_q;
  end

  // Outputs use the pre-edge index and shadow, so a load coinciding with a tick
  // first appears together with the new digit.
  always_comb begin
    nibble      = val_q[{idx_q, 2'b00} +: 4];
    seg_code    = seg_decode(nibble);
    digit_blank = blank_lz && (idx_q != '0) && ((val_q >> {idx_q, 2'b00}) == '0);
    led_d       = '0;
    sel_d       = '0;
    if (enable) begin
      led_d = {digit_blank ? 7'h00 : seg_code, dp_q[idx_q]};
      sel_d = NDIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q        <= '0;
      dp_q         <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      led_q        <= '0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      val_q        <= val_d;
      dp_q         <= dp_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      led_q        <= led_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign led        = led_q;
  assign sel        = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_multidigit_scan_display.sv
// Bench for multidigit_scan_display: scenario tasks compared against a cycle model
// derived from the count of enabled cycles since reset.
module tb_multidigit_scan_display;

  localparam int N  = 4;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  value;
  logic [3:0]   dp;
  logic         load;
  logic         blank_lz;
  logic         enable;
  logic [7:0]   led;
  logic [3:0]   sel;
  logic         frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  multidigit_scan_display #(.NDIGITS(N), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp         (dp),
    .load       (load),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .led        (led),
    .sel        (sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{8'h7E, 8'h0C, 8'hB6, 8'h9E, 8'hCC, 8'hDA, 8'hFA, 8'h0E,
                               8'hFE, 8'hDE, 8'hEE, 8'hF8, 8'hB0, 8'hBC, 8'hF2, 8'hE2};

  int         en_count = 0;
  logic [15:0] m_val   = '0;
  logic [3:0]  m_dp    = '0;
  logic [7:0]  exp_led = '0;
  logic [3:0]  exp_sel = '0;
  logic        exp_fd  = 1'b0;

  // The digit on display is simply (enabled cycles / SD) mod N, shown one cycle late.
  always @(posedge clk) begin
    int   digit;
    logic [3:0] nib;
    logic blank;
    if (reset) begin
      en_count <= 0;
      m_val    <= '0;
      m_dp     <= '0;
      exp_led  <= '0;
      exp_sel  <= '0;
      exp_fd   <= 1'b0;
    end else begin
      digit = (en_count / SD) % N;
      nib   = 4'(m_val >> (4 * digit));
      blank = blank_lz && (digit > 0) && ((m_val >> (4 * digit)) == 16'h0);
      if (enable) begin
        exp_sel <= 4'(1 << digit);
        exp_led <= (blank ? 8'h00 : seg_tab[nib]) | {7'b0, m_dp[digit]};
        en_count <= en_count + 1;
      end else begin
        exp_sel <= '0;
        exp_led <= '0;
      end
      exp_fd <= enable && (((en_count + 1) % (SD * N)) == 0);
      if (load) begin
        m_val <= value;
        m_dp  <= dp;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; value = 16'($urandom); dp = 4'($urandom);
    enable = 1'b1; blank_lz = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({led, sel, frame_done} !== 13'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: got led=%h sel=%b fd=%b required all zero", led, sel, frame_done);
      end
    end
  endtask

  task automatic test_scan_digits();
    int pulses;
    logic [7:0] want;
    reset = 1'b0; load = 1'b1; value = 16'h1234; dp = 4'h0; enable = 1'b1; blank_lz = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      load = 1'b0;
      n_checks++;
      if ({led, sel, frame_done} !== {exp_led, exp_sel, exp_fd}) begin
        n_fail++;
        $display("[TB] FAIL scan_model: got led=%h sel=%b fd=%b required led=%h sel=%b fd=%b",
                 led, sel, frame_done, exp_led, exp_sel, exp_fd);
      end
      if (i > 0) begin
        case (sel)
          4'b0001: want = 8'hCC;
          4'b0010: want = 8'h9E;
          4'b0100: want = 8'hB6;
          default: want = 8'h0C;
        endcase
        n_checks++;
        if (led !== want) begin
          n_fail++;
          $display("[TB] FAIL scan_digit: sel=%b got led=%h required %h", sel, led, want);
        end
      end
      if (i < 32 && frame_done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("[TB] FAIL frame_done_count: got %0d pulses in 32 cycles required 2", pulses);
    end
  endtask

  task automatic test_blanking();
    logic [7:0] want;
    load = 1'b1; value = 16'h00A0; dp = 4'h0; blank_lz = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (i == 20) blank_lz = 1'b0;
      n_checks++;
      if ({led, sel, frame_done} !== {exp_led, exp_sel, exp_fd}) begin
        n_fail++;
        $display("[TB] FAIL blank_model: got led=%h sel=%b required led=%h sel=%b", led, sel, exp_led, exp_sel);
      end
      if (i > 0) begin
        case (sel)
          4'b0001: want = 8'h7E;
          4'b0010: want = 8'hEE;
          default: want = (i <= 20) ? 8'h00 : 8'h7E;
        endcase
        n_checks++;
        if (led !== want) begin
          n_fail++;
          $display("[TB] FAIL blank_digit: cycle %0d sel=%b got led=%h required %h", i, sel, led, want);
        end
      end
    end
  endtask

  task automatic test_zero_with_dp();
    logic [7:0] want;
    load = 1'b1; value = 16'h0000; dp = 4'b0100; blank_lz = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      load = 1'b0;
      if (i > 0) begin
        case (sel)
          4'b0001: want = 8'h7E;
          4'b0100: want = 8'h01;
          default: want = 8'h00;
        endcase
        n_checks++;
        if (led !== want) begin
          n_fail++;
          $display("[TB] FAIL zero_dp_digit: sel=%b got led=%h required %h", sel, led, want);
        end
      end
    end
  endtask

  task automatic test_load_on_tick();
    logic [15:0] old_val, new_val;
    int d, nd;
    bit found;
    old_val = 16'($urandom);
    new_val = old_val;
    for (int k = 0; k < 4; k++) new_val[4*k +: 4] = old_val[4*k +: 4] ^ 4'($urandom_range(1, 15));
    load = 1'b1; value = old_val; dp = 4'h0; blank_lz = 1'b0; enable = 1'b1;
    @(negedge clk);
    load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 * SD; i++) begin
      @(negedge clk);
      if ((en_count % SD) == SD - 1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL load_tick_wait: tick not reached within %0d cycles", 2 * SD);
      return;
    end
    d  = (en_count / SD) % N;
    nd = (d + 1) % N;
    load = 1'b1; value = new_val;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if ({led, sel} !== {seg_tab[old_val[4*d +: 4]], 4'(1 << d)}) begin
      n_fail++;
      $display("[TB] FAIL load_tick_old: got led=%h sel=%b required led=%h sel=%b",
               led, sel, seg_tab[old_val[4*d +: 4]], 4'(1 << d));
    end
    @(negedge clk);
    n_checks++;
    if ({led, sel} !== {seg_tab[new_val[4*nd +: 4]], 4'(1 << nd)}) begin
      n_fail++;
      $display("[TB] FAIL load_tick_new: got led=%h sel=%b required led=%h sel=%b",
               led, sel, seg_tab[new_val[4*nd +: 4]], 4'(1 << nd));
    end
  endtask

  task automatic test_enable_pause();
    int d, rem;
    bit found;
    found = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 2 * SD * N; i++) begin
      @(negedge clk);
      if ((en_count % SD) == 1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("[TB] FAIL pause_wait: mid-digit point not reached");
      return;
    end
    d   = (en_count / SD) % N;
    rem = SD - (en_count % SD);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({led, sel} !== 12'h0 || {led, sel} !== {exp_led, exp_sel}) begin
        n_fail++;
        $display("[TB] FAIL pause_dark: got led=%h sel=%b required zero", led, sel);
      end
    end
    enable = 1'b1;
    for (int i = 0; i <= rem; i++) begin
      @(negedge clk);
      n_checks++;
      if (sel !== 4'(1 << ((i < rem) ? d : (d + 1) % N))) begin
        n_fail++;
        $display("[TB] FAIL pause_resume: cycle %0d got sel=%b required %b",
                 i, sel, 4'(1 << ((i < rem) ? d : (d + 1) % N)));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n_checks++;
      if ({led, sel, frame_done} !== {exp_led, exp_sel, exp_fd} || !$onehot0(sel)) begin
        n_fail++;
        $display("[TB] FAIL random_model: cycle %0d got led=%h sel=%b fd=%b required led=%h sel=%b fd=%b",
                 i, led, sel, frame_done, exp_led, exp_sel, exp_fd);
      end
      load     = ($urandom_range(0, 9) == 0);
      value    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp       = 4'($urandom);
      enable   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
    end
  endtask

  task automatic test_reset_mid_scan();
    reset = 1'b1; load = 1'b1; value = 16'($urandom) | 16'h0101; dp = 4'hF; enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({led, sel, frame_done} !== 13'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: got led=%h sel=%b fd=%b required all zero", led, sel, frame_done);
    end
    reset = 1'b0; load = 1'b0; enable = 1'b1; blank_lz = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({led, sel} !== {8'h7E, 4'b0001}) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_zero: got led=%h sel=%b required led=7e sel=0001", led, sel);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_checks++;
      if ({led, sel, frame_done} !== {exp_led, exp_sel, exp_fd}) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_model: got led=%h sel=%b required led=%h sel=%b", led, sel, exp_led, exp_sel);
      end
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0; enable = 1'b0;
    test_reset();
    test_scan_digits();
    test_blanking();
    test_zero_with_dp();
    test_load_on_tick();
    test_enable_pause();
    test_random();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
